// File: rtl/psum_pkg.sv
// psum_pkg: shared types and constants for the column-end psum collector.
//   state_t : collector FSM states (IDLE, ACCUM)
//   PASS_W  : width of the pass counter and of the numPasses port
package psum_pkg;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam int unsigned PASS_W = 8;

endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: synchronous show-ahead FIFO with an occupancy count.
//   clk, rst : clock, asynchronous active-high reset (flushes the FIFO)
//   push     : write wdata; accepted when not full, or when full with a pop
//   pop      : remove the head; ignored while empty
//   wdata    : entry to write
//   rdata    : current head (reads as zero while empty)
//   count    : registered number of stored entries
//   full     : count == DEPTH
//   empty    : count == 0
module psum_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/psum_collector.sv
// psum_collector: column-end drain unit. Accumulates the psum stream of one
// PE column over numPasses K-tile passes in a scratch buffer; final-pass sums
// go to an output FIFO drained by valid/ready.
//   clk, rst      : clock, asynchronous active-high reset (aborts any job)
//   start         : one-cycle job start, ignored while busy
//   numPasses     : pass count sampled on start (0 behaves as 1)
//   inPartialSum  : psum from the last PE, qualified by psumValid
//   arrayStall    : registered back-pressure, high when FIFO free slots <= 2
//   outPartialSum : FIFO head; outValid: FIFO non-empty; outReady: pop
//   busy          : job in progress; done: pulse after the final push
//   overflow      : sticky, final-pass psum dropped on a full FIFO
//   protoErr      : sticky, psumValid seen while idle
module psum_collector
    import psum_pkg::*;
#(
    parameter int unsigned accumulationPar = 32,
    parameter int unsigned vectorLen       = 8,
    parameter int unsigned fifoDepth       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PASS_W-1:0]          numPasses,
    input  logic [accumulationPar-1:0] inPartialSum,
    input  logic                       psumValid,
    output logic                       arrayStall,
    output logic [accumulationPar-1:0] outPartialSum,
    output logic                       outValid,
    input  logic                       outReady,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic                       protoErr
);

    localparam int unsigned IDX_W = $clog2(vectorLen);
    localparam int unsigned CNT_W = $clog2(fifoDepth + 1);

    state_t                     state;
    state_t                     state_next;
    logic [IDX_W-1:0]           idx;
    logic [PASS_W-1:0]          pass;
    logic [PASS_W-1:0]          last_pass;
    logic [accumulationPar-1:0] scratch [vectorLen];
    logic [accumulationPar-1:0] addend;
    logic [accumulationPar-1:0] sum;
    logic                       accept;
    logic                       idx_wrap;
    logic                       in_last_pass;
    logic                       final_psum;
    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CNT_W-1:0]           fifo_count;

    assign accept       = (state == ACCUM) && psumValid;
    assign idx_wrap     = (idx == IDX_W'(vectorLen - 1));
    assign in_last_pass = (pass == last_pass);
    assign final_psum   = accept && idx_wrap && in_last_pass;
    // Pass 0 starts from zero, so a single-pass job pushes the raw psum.
    assign addend       = (pass == '0) ? '0 : scratch[idx];
    assign sum          = addend + inPartialSum;
    assign push         = accept && in_last_pass;
    assign pop          = outValid && outReady;
    assign busy         = (state == ACCUM);
    assign outValid     = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = ACCUM;
            ACCUM:   if (final_psum) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            pass       <= '0;
            last_pass  <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            protoErr   <= 1'b0;
            arrayStall <= 1'b0;
        end else begin
            done       <= final_psum;
            arrayStall <= (fifo_count >= CNT_W'(fifoDepth - 2));
            if (state == IDLE) begin
                if (start) begin
                    idx       <= '0;
                    pass      <= '0;
                    last_pass <= (numPasses == '0) ? '0 : numPasses - PASS_W'(1);
                    overflow  <= 1'b0;
                    protoErr  <= 1'b0;
                end
                // Placed after the start clear: a psum in the start cycle still flags.
                if (psumValid) protoErr <= 1'b1;
            end else if (psumValid) begin
                if (idx_wrap) begin
                    idx  <= '0;
                    pass <= pass + PASS_W'(1);
                end else begin
                    idx <= idx + IDX_W'(1);
                end
                if (push && fifo_full && !pop) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !in_last_pass) scratch[idx] <= sum;
    end

    psum_fifo #(
        .WIDTH(accumulationPar),
        .DEPTH(fifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (sum),
        .rdata (outPartialSum),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: randomized and directed bench for psum_collector.
// Reference model: per-job list of received psums, final sums computed as
// plain column sums over passes, output FIFO held as a bounded queue.
module tb_psum_collector;

    localparam int W = 32;
    localparam int V = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   numPasses;
    logic [W-1:0] inPartialSum;
    logic         psumValid;
    logic         arrayStall;
    logic [W-1:0] outPartialSum;
    logic         outValid;
    logic         outReady;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         protoErr;

    always #5 clk = ~clk;

    psum_collector #(
        .accumulationPar(W),
        .vectorLen(V),
        .fifoDepth(D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .numPasses     (numPasses),
        .inPartialSum  (inPartialSum),
        .psumValid     (psumValid),
        .arrayStall    (arrayStall),
        .outPartialSum (outPartialSum),
        .outValid      (outValid),
        .outReady      (outReady),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .protoErr      (protoErr)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model state
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_ps[$];
    logic [W-1:0] job_vals[$];
    logic [W-1:0] popped[$];
    bit           m_busy, m_done, m_ovf, m_perr, m_stall;
    int           m_n, m_k;

    task automatic reset_model();
        m_q.delete();
        m_ps.delete();
        m_busy = 0; m_done = 0; m_ovf = 0; m_perr = 0; m_stall = 0;
        m_n = 1; m_k = 0;
    endtask

    task automatic compare_outputs();
        check_eq("outValid", 32'(outValid), 32'(m_q.size() != 0));
        check_eq("outPartialSum", outPartialSum, (m_q.size() != 0) ? m_q[0] : '0);
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("protoErr", 32'(protoErr), 32'(m_perr));
        check_eq("arrayStall", 32'(arrayStall), 32'(m_stall));
    endtask

    // Inputs are already driven; predict the edge, clock it, then compare.
    task automatic cycle();
        bit           pop, push, nxt_done, nxt_stall;
        logic [W-1:0] val;
        int           sz;
        sz        = m_q.size();
        nxt_stall = (D - sz) <= 2;
        nxt_done  = 0;
        push      = 0;
        val       = '0;
        pop       = (sz != 0) && outReady;
        if (!m_busy) begin
            if (start) begin
                m_busy = 1;
                m_n    = (numPasses == 0) ? 1 : int'(numPasses);
                m_ovf  = 0;
                m_perr = 0;
                m_k    = 0;
                m_ps.delete();
            end
            if (psumValid) m_perr = 1;
        end else if (psumValid) begin
            m_ps.push_back(inPartialSum);
            if (m_k / V == m_n - 1) begin
                for (int j = 0; j < m_n; j++) val = val + m_ps[j * V + (m_k % V)];
                push = 1;
            end
            m_k++;
            if (m_k == m_n * V) begin
                m_busy   = 0;
                nxt_done = 1;
            end
        end
        if (pop) begin
            popped.push_back(outPartialSum);
            void'(m_q.pop_front());
        end
        if (push) begin
            if (sz < D || pop) m_q.push_back(val);
            else m_ovf = 1;
        end
        @(posedge clk);
        @(negedge clk);
        m_done  = nxt_done;
        m_stall = nxt_stall;
        compare_outputs();
    endtask

    task automatic do_reset();
        start = 0; psumValid = 0;
        #1 rst = 1'b1;
        #1;
        reset_model();
        compare_outputs();
        @(negedge clk);
        rst = 1'b0;
        compare_outputs();
    endtask

    task automatic feed(input bit v, input logic [W-1:0] d);
        psumValid    = v;
        inPartialSum = d;
        cycle();
        psumValid = 0;
    endtask

    task automatic run_job(input int np, input int ready_pct, input bit noise);
        int idx   = 0;
        int guard = 0;
        start = 1; numPasses = 8'(np); psumValid = 0;
        cycle();
        start = 0;
        while (idx < job_vals.size() && guard < 4000) begin
            guard++;
            outReady = ($urandom_range(99) < ready_pct);
            start    = noise && ($urandom_range(15) == 0);
            if (!arrayStall && (!noise || $urandom_range(3) != 0)) begin
                psumValid = 1; inPartialSum = job_vals[idx]; idx++;
            end else begin
                psumValid = 0;
            end
            cycle();
        end
        start = 0; psumValid = 0;
        check_eq("job_fed", 32'(idx), 32'(job_vals.size()));
    endtask

    task automatic drain();
        start = 0; psumValid = 0; outReady = 1;
        for (int c = 0; c < 2 * D + 2 && m_q.size() != 0; c++) cycle();
        cycle();
        check_eq("drain_empty", 32'(outValid), 32'(0));
    endtask

    initial begin
        int fed;
        start = 0; numPasses = 0; inPartialSum = 0; psumValid = 0; outReady = 0;
        rst = 1'b1;
        #1;
        reset_model();
        compare_outputs();
        @(negedge clk);
        rst = 1'b0;
        compare_outputs();

        // Single pass: raw psums emerge in order
        job_vals.delete(); popped.delete();
        for (int i = 0; i < V; i++) job_vals.push_back(W'(i + 1));
        run_job(1, 100, 0);
        drain();
        check_eq("p1_count", 32'(popped.size()), 32'(V));
        for (int i = 0; i < V && i < popped.size(); i++) check_eq("p1_val", popped[i], 32'(i + 1));

        // Three passes with a negative final pass
        job_vals.delete(); popped.delete();
        for (int i = 0; i < V; i++) job_vals.push_back(W'(10 * (i + 1)));
        for (int i = 0; i < V; i++) job_vals.push_back(W'(i + 1));
        for (int i = 0; i < V; i++) job_vals.push_back(-W'(5));
        run_job(3, 100, 0);
        drain();
        for (int i = 0; i < V && i < popped.size(); i++) check_eq("p3_val", popped[i], 32'(11 * (i + 1) - 5));

        // Wrap-around without flags
        job_vals.delete(); popped.delete();
        for (int i = 0; i < V; i++) job_vals.push_back(32'h7FFF_FFFF);
        for (int i = 0; i < V; i++) job_vals.push_back(32'h1);
        run_job(2, 100, 0);
        drain();
        check_eq("wrap_val", popped[0], 32'h8000_0000);
        check_eq("wrap_ovf", 32'(overflow), 32'(0));

        // Back-pressure, then a forced push onto a full FIFO
        job_vals.delete(); popped.delete();
        for (int i = 0; i < V; i++) job_vals.push_back($urandom);
        start = 1; numPasses = 1; outReady = 0;
        cycle();
        start = 0; fed = 0;
        for (int c = 0; c < 10; c++) begin
            if (!arrayStall) begin feed(1, job_vals[fed]); fed++; end
            else feed(0, '0);
        end
        check_eq("stall_fed", 32'(fed), 32'(3));
        check_eq("stall_high", 32'(arrayStall), 32'(1));
        feed(1, job_vals[3]);
        feed(1, job_vals[4]);
        check_eq("ovf_set", 32'(overflow), 32'(1));
        fed = 5;
        outReady = 1;
        for (int c = 0; c < 40 && fed < V; c++) begin
            if (!arrayStall) begin feed(1, job_vals[fed]); fed++; end
            else feed(0, '0);
        end
        drain();
        check_eq("ovf_count", 32'(popped.size()), 32'(V - 1));
        for (int i = 0; i < V - 1 && i < popped.size(); i++)
            check_eq("ovf_val", popped[i], job_vals[(i < 4) ? i : i + 1]);

        // Reset in the middle of a three-pass job, then a clean single pass
        start = 1; numPasses = 3; outReady = 1;
        cycle();
        start = 0;
        feed(1, 32'd100);
        feed(1, 32'd200);
        do_reset();
        job_vals.delete(); popped.delete();
        for (int i = 0; i < V; i++) job_vals.push_back($urandom);
        run_job(1, 100, 0);
        drain();
        for (int i = 0; i < V && i < popped.size(); i++) check_eq("post_rst_val", popped[i], job_vals[i]);

        // psumValid while idle, then start clears the flag
        feed(1, 32'hDEAD);
        check_eq("perr_set", 32'(protoErr), 32'(1));
        check_eq("perr_nopush", 32'(outValid), 32'(0));
        start = 1; numPasses = 0;
        cycle();
        start = 0;
        check_eq("perr_clear", 32'(protoErr), 32'(0));
        job_vals.delete();
        for (int i = 0; i < V; i++) job_vals.push_back($urandom);
        for (int i = 0; i < V; i++) begin
            outReady = 1;
            feed(1, job_vals[i]);
        end
        drain();

        // Randomized jobs
        for (int j = 0; j < 25; j++) begin
            int np;
            int tot;
            np  = $urandom_range(0, 4);
            tot = ((np == 0) ? 1 : np) * V;
            job_vals.delete();
            for (int i = 0; i < tot; i++) job_vals.push_back($urandom);
            if ($urandom_range(3) == 0) feed(1, $urandom);
            run_job(np, $urandom_range(30, 100), 1);
            if ($urandom_range(1) == 1) drain();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
